// File: rtl/gpio_vector_seq_if.sv
// Wishbone classic slave bus bundle for gpio_vector_seq.
// Ports:
//   wb_adr_i/wb_dat_i/wb_sel_i/wb_we_i/wb_cyc_i/wb_stb_i : master -> slave request
//   wb_ack_o/wb_dat_o                                    : slave -> master response
interface gpio_vector_seq_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_ack_o, wb_dat_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_ack_o, wb_dat_o
  );
endinterface

// File: rtl/gpio_vector_seq.sv
// GPIO vector sequencer: plays a table of DEPTH pattern words onto seq_out,
// holding each for DWELL+1 cycles, and captures seq_in at the end of every
// step into a matching capture table. Optional looping, level interrupt on
// completion. Register access over a Wishbone classic slave.
// Ports:
//   wb_clk_i   : clock
//   wb_rst_i   : asynchronous active-high reset
//   wb         : Wishbone slave bundle (gpio_vector_seq_if.slave)
//   seq_out    : current pattern word
//   seq_in     : GPIO input vector, captured per step
//   seq_active : high while running
//   seq_irq    : DONE & IRQ_EN
module gpio_vector_seq #(
  parameter logic [31:0] BASE_ADR = 32'h2100_0100,
  parameter int          DEPTH    = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  gpio_vector_seq_if.slave   wb,
  output logic [31:0]        seq_out,
  input  logic [31:0]        seq_in,
  output logic               seq_active,
  output logic               seq_irq
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     idx, len;
  logic [15:0]       dwell, cnt;
  logic [11:0]       loop_cnt;
  logic              loop_en, irq_en, done_flag;
  logic [DEPTH-1:0][31:0] pat, cap;

  // bus decode
  logic [7:0]    off;
  logic [3:0]    ent;
  logic [IW-1:0] ent_i;
  logic          hit, acc, wr, aligned, ent_ok, pat_sel, cap_sel;
  logic          ctrl_wr, start_req, stop_req;
  logic [31:0]   rd_data;

  assign off     = wb.wb_adr_i[7:0];
  assign ent     = off[5:2];
  assign ent_i   = ent[IW-1:0];
  assign hit     = (wb.wb_adr_i[31:8] == BASE_ADR[31:8]);
  // !ack gate turns a held strobe into one ack every other cycle
  assign acc     = wb.wb_cyc_i & wb.wb_stb_i & hit & ~wb.wb_ack_o;
  assign wr      = acc & wb.wb_we_i & wb.wb_sel_i[0];
  assign aligned = (off[1:0] == 2'b00);
  assign ent_ok  = aligned && ({1'b0, ent} < 5'(DEPTH));
  assign pat_sel = (off[7:6] == 2'b01) && ent_ok;
  assign cap_sel = (off[7:6] == 2'b10) && ent_ok;

  assign ctrl_wr   = wr && (off == 8'h00);
  assign stop_req  = ctrl_wr & wb.wb_dat_i[1];
  assign start_req = ctrl_wr & wb.wb_dat_i[0] & ~wb.wb_dat_i[1];

  // sequencer step control
  logic tick, last, do_start, do_adv, do_wrap, do_done;
  assign tick = (state == RUN) && (cnt == 16'd0);
  assign last = (idx == len);

  always_comb begin
    state_nxt = state;
    do_start  = 1'b0;
    do_adv    = 1'b0;
    do_wrap   = 1'b0;
    do_done   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_req) begin
          state_nxt = RUN;
          do_start  = 1'b1;
        end
      end
      RUN: begin
        if (stop_req) begin
          state_nxt = IDLE;
        end else if (tick) begin
          if (!last)        do_adv  = 1'b1;
          else if (loop_en) do_wrap = 1'b1;
          else begin
            state_nxt = DONE;
            do_done   = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // sequencer datapath
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      idx      <= '0;
      cnt      <= '0;
      loop_cnt <= '0;
      seq_out  <= '0;
      for (int i = 0; i < DEPTH; i++) cap[i] <= '0;
    end else if (do_start) begin
      idx      <= '0;
      cnt      <= dwell;
      loop_cnt <= '0;
      seq_out  <= pat[0];
    end else if (state == RUN && !stop_req) begin
      if (tick) begin
        cap[idx] <= seq_in;
        cnt      <= dwell;
        if (do_adv) begin
          idx     <= idx + 1'b1;
          seq_out <= pat[idx + 1'b1];
        end else if (do_wrap) begin
          idx      <= '0;
          seq_out  <= pat[0];
          loop_cnt <= loop_cnt + 12'd1;
        end
      end else begin
        cnt <= cnt - 16'd1;
      end
    end
  end

  // registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      len       <= '0;
      dwell     <= '0;
      loop_en   <= 1'b0;
      irq_en    <= 1'b0;
      done_flag <= 1'b0;
      for (int i = 0; i < DEPTH; i++) pat[i] <= '0;
    end else begin
      if (ctrl_wr) begin
        loop_en <= wb.wb_dat_i[2];
        irq_en  <= wb.wb_dat_i[3];
      end
      // completion beats a simultaneous DONE_CLR
      if (do_done)                           done_flag <= 1'b1;
      else if (do_start)                     done_flag <= 1'b0;
      else if (ctrl_wr && wb.wb_dat_i[4])    done_flag <= 1'b0;
      if (wr && off == 8'h04 && state != RUN) len   <= wb.wb_dat_i[IW-1:0];
      if (wr && off == 8'h08 && state != RUN) dwell <= wb.wb_dat_i[15:0];
      if (wr && pat_sel)                      pat[ent_i] <= wb.wb_dat_i;
    end
  end

  // read mux
  always_comb begin
    rd_data = '0;
    if (off == 8'h00)
      rd_data = {27'd0, irq_en, loop_en, 1'b0, done_flag, state == RUN};
    else if (off == 8'h04)
      rd_data = {28'd0, 4'(len)};
    else if (off == 8'h08)
      rd_data = {16'd0, dwell};
    else if (off == 8'h0C)
      rd_data = {16'd0, loop_cnt, 4'(idx)};
    else if (pat_sel)
      rd_data = pat[ent_i];
    else if (cap_sel)
      rd_data = cap[ent_i];
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= '0;
    end else begin
      wb.wb_ack_o <= acc;
      if (acc) wb.wb_dat_o <= rd_data;
    end
  end

  assign seq_active = (state == RUN);
  assign seq_irq    = done_flag & irq_en;

endmodule

// File: tb/tb_gpio_vector_seq.sv
// Scoreboard bench for gpio_vector_seq: bus transfers push expected read data,
// run phases push the expected per-cycle seq_out trace; a negedge monitor pops
// and compares on every ack and every active cycle.
module tb_gpio_vector_seq;
  localparam logic [31:0] BASE = 32'h2100_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] seq_in, seq_out;
  logic        seq_active, seq_irq;
  logic [31:0] cc = '0;

  gpio_vector_seq_if bus();

  gpio_vector_seq #(.BASE_ADR(BASE), .DEPTH(8)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wb        (bus),
    .seq_out   (seq_out),
    .seq_in    (seq_in),
    .seq_active(seq_active),
    .seq_irq   (seq_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cc <= cc + 32'd1;
  // input carries a time stamp and the current step's pattern
  assign seq_in = {cc[15:0], seq_out[15:0]};

  typedef struct {bit rd; logic [31:0] adr; logic [31:0] exp;} bus_exp_t;
  bus_exp_t    bq[$];
  logic [31:0] tq[$];
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // monitor
  always @(negedge clk) begin : mon
    bus_exp_t e;
    if (bus.wb_ack_o === 1'b1) begin
      if (bq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected ack: dat %h", bus.wb_dat_o);
      end else begin
        e = bq.pop_front();
        if (e.rd) chk($sformatf("read adr %h", e.adr), bus.wb_dat_o, e.exp);
      end
    end
    if (seq_active === 1'b1) begin
      if (tq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected active cycle: seq_out %h", seq_out);
      end else begin
        chk("seq_out trace", seq_out, tq.pop_front());
      end
    end
  end

  task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat);
    int n;
    @(negedge clk);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
    bus.wb_adr_i = adr;  bus.wb_dat_i = dat;  bus.wb_sel_i = 4'hf;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.wb_ack_o !== 1'b1 && n < 16);
    if (bus.wb_ack_o !== 1'b1) begin
      n_chk++; n_fail++;
      $display("FAIL ack timeout: adr %h", adr);
    end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] dat);
    bq.push_back('{1'b0, BASE | 32'(off), 32'd0});
    xfer(1'b1, BASE | 32'(off), dat);
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp);
    bq.push_back('{1'b1, BASE | 32'(off), exp});
    xfer(1'b0, BASE | 32'(off), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t0;
    logic [3:0]  acks;
    int          nack;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0;   bus.wb_dat_i = '0;   bus.wb_sel_i = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset seq_out", seq_out, 32'd0);
    chk("reset active", 32'(seq_active), 32'd0);
    chk("reset irq", 32'(seq_irq), 32'd0);
    chk("reset ack", 32'(bus.wb_ack_o), 32'd0);
    rst = 1'b0;
    rd(8'h00, 32'h0); rd(8'h04, 32'h0); rd(8'h08, 32'h0);
    rd(8'h0C, 32'h0); rd(8'h44, 32'h0); rd(8'h88, 32'h0);

    // single pass, DWELL=2
    wr(8'h40, 32'd1); wr(8'h44, 32'd2); wr(8'h48, 32'd3); wr(8'h4C, 32'd4);
    wr(8'h04, 32'd3); wr(8'h08, 32'd2);
    for (int p = 1; p <= 4; p++) repeat (3) tq.push_back(32'(p));
    wr(8'h00, 32'h09);
    t0 = cc;
    repeat (14) @(negedge clk);
    chk("pass trace drained", 32'(tq.size()), 32'd0);
    chk("pass active", 32'(seq_active), 32'd0);
    chk("pass irq", 32'(seq_irq), 32'd1);
    chk("pass hold", seq_out, 32'd4);
    rd(8'h00, 32'h12);
    rd(8'h0C, 32'h3);
    for (int i = 0; i < 4; i++)
      rd(8'h80 + 8'(4*i), {16'(t0 + 32'(3*i + 2)), 16'(i + 1)});
    wr(8'h00, 32'h18);
    rd(8'h00, 32'h10);
    chk("done_clr irq", 32'(seq_irq), 32'd0);

    // looping run with ignored LEN write and ignored restart, then STOP
    for (int l = 0; l < 2; l++)
      for (int p = 1; p <= 4; p++) repeat (3) tq.push_back(32'(p));
    tq.push_back(32'd1); tq.push_back(32'd1);
    wr(8'h00, 32'h0D);
    wr(8'h04, 32'd1);
    wr(8'h00, 32'h0D);
    repeat (20) @(negedge clk);
    wr(8'h00, 32'h0E);
    repeat (2) @(negedge clk);
    chk("loop trace drained", 32'(tq.size()), 32'd0);
    chk("loop stop active", 32'(seq_active), 32'd0);
    chk("loop stop hold", seq_out, 32'd1);
    rd(8'h0C, 32'h20);
    rd(8'h00, 32'h18);
    rd(8'h04, 32'h3);

    // START|STOP together stays idle
    wr(8'h00, 32'h03);
    repeat (2) @(negedge clk);
    chk("start+stop active", 32'(seq_active), 32'd0);
    rd(8'h00, 32'h0);

    // DWELL=0 over all 8 entries; LEN masking
    wr(8'h04, 32'hFF);
    rd(8'h04, 32'h7);
    wr(8'h08, 32'd0);
    wr(8'h50, 32'd5); wr(8'h54, 32'd6); wr(8'h58, 32'd7); wr(8'h5C, 32'd8);
    for (int p = 1; p <= 8; p++) tq.push_back(32'(p));
    wr(8'h00, 32'h01);
    repeat (10) @(negedge clk);
    chk("fast trace drained", 32'(tq.size()), 32'd0);
    chk("fast hold", seq_out, 32'd8);
    chk("fast irq masked", 32'(seq_irq), 32'd0);
    rd(8'h00, 32'h02);
    rd(8'h0C, 32'h7);

    // out-of-table entry inside the window: acks, reads 0, no aliasing
    wr(8'h60, 32'hDEAD_BEEF);
    rd(8'h60, 32'h0);
    rd(8'h40, 32'h1);

    // reset mid-run
    wr(8'h08, 32'd2);
    tq.push_back(32'd1); tq.push_back(32'd1); tq.push_back(32'd1);
    tq.push_back(32'd2); tq.push_back(32'd2);
    wr(8'h00, 32'h01);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrun rst seq_out", seq_out, 32'd0);
    chk("midrun rst active", 32'(seq_active), 32'd0);
    chk("midrun rst dat_o", bus.wb_dat_o, 32'd0);
    chk("midrun rst ack", 32'(bus.wb_ack_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("midrun trace drained", 32'(tq.size()), 32'd0);
    rd(8'h80, 32'h0);
    rd(8'h40, 32'h0);
    rd(8'h00, 32'h0);

    // back-to-back reads of an unmapped offset
    @(negedge clk);
    bq.push_back('{1'b1, BASE | 32'h3C, 32'd0});
    bq.push_back('{1'b1, BASE | 32'h3C, 32'd0});
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = BASE | 32'h3C; bus.wb_sel_i = 4'hf;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      acks[3-k] = bus.wb_ack_o;
    end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    chk("b2b ack pattern", 32'(acks), 32'hA);

    // miss outside the window: never acked, no side effect
    @(negedge clk);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
    bus.wb_adr_i = 32'h2100_0204; bus.wb_dat_i = 32'd5;
    nack = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.wb_ack_o === 1'b1) nack++;
    end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    chk("miss ack count", 32'(nack), 32'd0);
    rd(8'h04, 32'h0);

    repeat (3) @(negedge clk);
    chk("bus queue empty", 32'(bq.size()), 32'd0);
    chk("trace queue empty", 32'(tq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gpio_vector_seq.md
GPIO_VECTOR_SEQ -- requirements
Module: gpio_vector_seq

Interface
REQ-001 SHALL have parameter BASE_ADR, default 32'h2100_0100, Wishbone window base; decode compares address bits [31:8].
REQ-002 SHALL have parameter DEPTH, default 8, number of pattern/capture entries (power of 2, 2..16).
REQ-003 SHALL have ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wb_adr_i  in  32  address.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte select.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  cycle.
- wb_stb_i  in  1  strobe.
- wb_ack_o  out  1  acknowledge.
- wb_dat_o  out  32  read data.
- seq_out  out  32  pattern word driving the GPIO vector output data.
- seq_in  in  32  GPIO vector input data, sampled per step.
- seq_active  out  1  high while the sequencer is running.
- seq_irq  out  1  level interrupt, DONE & IRQ_EN.

Function
REQ-004 SHALL acknowledge an access one cycle after wb_cyc_i & wb_stb_i & window hit & !wb_ack_o; wb_ack_o SHALL be a single-cycle pulse; non-hit accesses SHALL never be acked.
REQ-005 SHALL perform a write only when wb_we_i & wb_sel_i[0] on the acking cycle; unmapped offsets inside the window SHALL ack and read 0.
REQ-006 SHALL implement these registers (offset = wb_adr_i[7:0]):
- 0x00 CTRL: W bit0 START, bit1 STOP, bit2 LOOP, bit3 IRQ_EN, bit4 DONE_CLR (W1C); R {27'd0, IRQ_EN, LOOP, 1'b0, DONE, BUSY}.
- 0x04 LEN: [3:0] last index (entries-1), masked to log2(DEPTH) bits.
- 0x08 DWELL: [15:0] cycles per step minus 1.
- 0x0C STEP: R-only, {16'd0, loop_count[11:0], idx[3:0]}.
- 0x40+4*i PAT[i]: R/W 32-bit pattern entry.
- 0x80+4*i CAP[i]: R-only captured seq_in.
REQ-007 SHALL have FSM states IDLE, RUN, DONE.
REQ-008 START in IDLE or DONE SHALL, next cycle: enter RUN, idx=0, loop_count=0, counter=DWELL, seq_out=PAT[0], clear DONE.
REQ-009 In RUN the counter SHALL decrement each cycle; at counter==0: CAP[idx]<=seq_in, counter reloads DWELL.
REQ-010 At counter==0 with idx<LEN: idx+1 and seq_out=PAT[idx+1] on the same edge.
REQ-011 At counter==0 with idx==LEN: if LOOP, idx=0, seq_out=PAT[0], loop_count+1 (wraps at 4095->0); else enter DONE, set DONE.
REQ-012 Each step SHALL therefore last exactly DWELL+1 cycles; DWELL=0 SHALL advance every cycle.
REQ-013 In DONE seq_out SHALL hold the last pattern; seq_active SHALL be low outside RUN.
REQ-014 STOP in RUN SHALL enter IDLE next cycle, seq_out holds, DONE not set; START and STOP in the same write: STOP wins.
REQ-015 START while in RUN SHALL be ignored (no restart).
REQ-016 Writes to LEN and DWELL while in RUN SHALL be ignored; writes to PAT SHALL be accepted and take effect when that entry is next loaded.
REQ-017 DONE_CLR SHALL clear DONE; if DONE is set on the same edge, set SHALL win.
REQ-018 LOOP and IRQ_EN SHALL update on every CTRL write, including while in RUN.

Reset
REQ-019 wb_rst_i high SHALL asynchronously force: state IDLE, seq_out=0, wb_ack_o=0, wb_dat_o=0, seq_active=0, seq_irq=0, DONE=0, LOOP=0, IRQ_EN=0, LEN=0, DWELL=0, idx=0, loop_count=0, counter=0.
REQ-020 PAT and CAP contents SHALL be reset to 0.
REQ-021 Reset asserted mid-RUN SHALL abort the run with no further capture.

Verification
REQ-022 PAT[0..3]=1,2,3,4, LEN=3, DWELL=2, IRQ_EN=1, START -> seq_out 1,2,3,4 for 3 cycles each; CAP[0..3] hold seq_in; DONE=1, seq_irq=1.
REQ-023 Same setup with LOOP=1 for 26 cycles, then STOP -> seq_out returns to 1 after 4; STEP loop_count=2; IDLE with DONE=0.
REQ-024 CTRL write 0x3 (START|STOP) in IDLE -> state stays IDLE and seq_active=0.
REQ-025 DWELL=0, LEN=7 -> seq_out changes every cycle; DONE is set 8 cycles after RUN entry.
REQ-026 Assert wb_rst_i mid-RUN -> all outputs 0 immediately; back-to-back bus reads ack every other cycle; a read of 0x3C acks and returns 0.
